// File: rtl/write_back_pkg.sv
// Shared write-back types: register-file write-port control, arbiter state and
// the default sizing constants used by wb_port_arbiter.
package write_back_pkg;

  typedef struct packed {
    logic       write_enable;
    logic [4:0] addr_rd;
  } reg_file_write_params_t;

  typedef enum logic {
    PIPE_PRI = 1'b0,
    LOAD_PRI = 1'b1
  } wb_arb_state_t;

  localparam int WB_LQ_DEPTH_DEF     = 2;
  localparam int WB_STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/wb_load_queue.sv
// Load-return FIFO. Caller gates enq/deq against full/empty; every entry's rd
// is exposed with its valid bit so hazard matching can see the whole queue.
module wb_load_queue #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enq,
  input  logic [4:0]            enq_rd,
  input  logic [31:0]           enq_data,
  input  logic                  deq,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic [4:0]            head_rd,
  output logic [31:0]           head_data,
  output logic [DEPTH-1:0]      ent_vld,
  output logic [DEPTH-1:0][4:0] ent_rd
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [DEPTH-1:0][31:0]    data_mem;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ent_vld  <= '0;
      ent_rd   <= '0;
      data_mem <= '0;
    end else begin
      if (enq) begin
        ent_rd[wr_ptr]   <= enq_rd;
        data_mem[wr_ptr] <= enq_data;
        ent_vld[wr_ptr]  <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = ent_rd[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline and queued load returns.
// Optional WB_ARB_FORWARD_EN adds chk_rs1/chk_rs2 and the lq_hazard output.
module wb_port_arbiter
  import write_back_pkg::*;
#(
  parameter  int LQ_DEPTH     = WB_LQ_DEPTH_DEF,
  parameter  int STARVE_LIMIT = WB_STARVE_LIMIT_DEF,
  localparam int LQ_CW        = $clog2(LQ_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pipe_valid,
  output logic                   pipe_ready,
  input  reg_file_write_params_t pipe_params,
  input  logic [31:0]            pipe_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_rd,
  input  logic [31:0]            ld_data,
  output reg_file_write_params_t rf_write_params,
  output logic [31:0]            rf_write_data,
  output logic [LQ_CW-1:0]       lq_count
`ifdef WB_ARB_FORWARD_EN
  ,
  input  logic [4:0]             chk_rs1,
  input  logic [4:0]             chk_rs2,
  output logic                   lq_hazard
`endif
);

  wb_arb_state_t    state, state_nxt;
  logic [3:0]       starve_cnt, cnt_nxt;
  logic             lq_full, lq_empty, enq, deq, pipe_need, pipe_grant, full_nxt;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic [LQ_CW-1:0] count_nxt;
`ifdef WB_ARB_FORWARD_EN
  logic [LQ_DEPTH-1:0]      ent_vld, ent_hit;
  logic [LQ_DEPTH-1:0][4:0] ent_rd;
`endif

  wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq       (enq),
    .enq_rd    (ld_rd),
    .enq_data  (ld_data),
    .deq       (deq),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty),
    .head_rd   (head_rd),
    .head_data (head_data),
`ifdef WB_ARB_FORWARD_EN
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
`else
    .ent_vld   (),
    .ent_rd    ()
`endif
  );

  // pipe_ready looks at write_enable only, never pipe_valid: no-write requests
  // are always absorbed, port-needing ones stall only in LOAD_PRI.
  always_comb begin
    pipe_need  = pipe_valid && pipe_params.write_enable;
    pipe_ready = (state == PIPE_PRI) || !pipe_params.write_enable;
    ld_ready   = !lq_full;
    enq        = ld_valid && ld_ready;
    pipe_grant = 1'b0;
    deq        = 1'b0;
    if (state == PIPE_PRI) begin
      pipe_grant = pipe_need;
      deq        = !pipe_need && !lq_empty;
    end else begin
      deq        = !lq_empty;
    end

    cnt_nxt = starve_cnt;
    if (deq || lq_empty)
      cnt_nxt = '0;
    else if (pipe_grant && starve_cnt < 4'(STARVE_LIMIT))
      cnt_nxt = starve_cnt + 4'd1;

    count_nxt = lq_count + LQ_CW'(enq) - LQ_CW'(deq);
    full_nxt  = (count_nxt == LQ_CW'(LQ_DEPTH));

    state_nxt = state;
    case (state)
      PIPE_PRI: if (cnt_nxt == 4'(STARVE_LIMIT) || full_nxt) state_nxt = LOAD_PRI;
      LOAD_PRI: if (deq || lq_empty)                         state_nxt = PIPE_PRI;
      default:  state_nxt = PIPE_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PIPE_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  // x0 targets still consume the grant but never raise write_enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_params <= '0;
      rf_write_data   <= '0;
    end else if (pipe_grant) begin
      rf_write_params.write_enable <= (pipe_params.addr_rd != 5'd0);
      rf_write_params.addr_rd      <= pipe_params.addr_rd;
      rf_write_data                <= pipe_data;
    end else if (deq) begin
      rf_write_params.write_enable <= (head_rd != 5'd0);
      rf_write_params.addr_rd      <= head_rd;
      rf_write_data                <= head_data;
    end else begin
      rf_write_params.write_enable <= 1'b0;
    end
  end

`ifdef WB_ARB_FORWARD_EN
  for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_hit
    assign ent_hit[i] = ent_vld[i] && (ent_rd[i] != 5'd0) &&
                        ((ent_rd[i] == chk_rs1) || (ent_rd[i] == chk_rs2));
  end
  assign lq_hazard = (|ent_hit) ||
                     (enq && (ld_rd != 5'd0) && ((ld_rd == chk_rs1) || (ld_rd == chk_rs2)));
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// up front and a negedge monitor pops/compares each write the DUT emits.
module tb_wb_port_arbiter;
  import write_back_pkg::*;

  localparam int LQ_DEPTH     = 2;
  localparam int STARVE_LIMIT = 3;
  localparam int LQ_CW        = $clog2(LQ_DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   pipe_valid, pipe_ready, ld_valid, ld_ready;
  reg_file_write_params_t pipe_params, rf_write_params;
  logic [31:0]            pipe_data, ld_data, rf_write_data;
  logic [4:0]             ld_rd;
  logic [LQ_CW-1:0]       lq_count;
`ifdef WB_ARB_FORWARD_EN
  logic [4:0]             chk_rs1 = 5'd0, chk_rs2 = 5'd0;
  logic                   lq_hazard;
`endif

  wb_port_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pipe_valid      (pipe_valid),
    .pipe_ready      (pipe_ready),
    .pipe_params     (pipe_params),
    .pipe_data       (pipe_data),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_rd           (ld_rd),
    .ld_data         (ld_data),
    .rf_write_params (rf_write_params),
    .rf_write_data   (rf_write_data),
    .lq_count        (lq_count)
`ifdef WB_ARB_FORWARD_EN
    ,
    .chk_rs1         (chk_rs1),
    .chk_rs2         (chk_rs2),
    .lq_hazard       (lq_hazard)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back('{rd, d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid  = 1'b0;
    pipe_params = '0;
    pipe_data   = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    pipe_valid               = 1'b1;
    pipe_params.write_enable = 1'b1;
    pipe_params.addr_rd      = rd;
    pipe_data                = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  // Monitor: every write the DUT emits must be the next expected one.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rf_write_params.write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got rd %0d data %0h, want no write",
                 rf_write_params.addr_rd, rf_write_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_rd",   32'(rf_write_params.addr_rd), 32'(mon_e.rd));
        chk("wr_data", rf_write_data, mon_e.data);
      end
    end
  end

  initial begin
    idle();
    @(negedge clk);
    chk("rst_we",      32'(rf_write_params.write_enable), 0);
    chk("rst_addr",    32'(rf_write_params.addr_rd), 0);
    chk("rst_data",    rf_write_data, 0);
    chk("rst_count",   32'(lq_count), 0);
    chk("rst_ldready", 32'(ld_ready), 1);
    cyc();
    reset_n = 1'b1;

    // Pipe-only write appears the following cycle.
    exp_wr(5'd5, 32'h1234);
    pipe(5'd5, 32'h1234);
    @(negedge clk); chk("t1_pready", 32'(pipe_ready), 1);
    cyc(); idle();
    @(negedge clk); chk("t1_we", 32'(rf_write_params.write_enable), 1);
    chk("t1_count", 32'(lq_count), 0);
    cyc();

    // Starvation: load rd 7 waits out three pipe grants, then wins one cycle.
    exp_wr(5'd11, 32'hA001); exp_wr(5'd12, 32'hA002); exp_wr(5'd13, 32'hA003);
    exp_wr(5'd7,  32'h77);   exp_wr(5'd14, 32'hA004); exp_wr(5'd15, 32'hA005);
    ld(5'd7, 32'h77);
    @(negedge clk); chk("st_ldready", 32'(ld_ready), 1);
    cyc(); idle();
    for (int i = 1; i <= 3; i++) begin
      pipe(5'(10 + i), 32'hA000 + 32'(i));
      @(negedge clk); chk("st_pready", 32'(pipe_ready), 1);
      cyc();
    end
    pipe(5'd14, 32'hA004);
    @(negedge clk); chk("st_stall", 32'(pipe_ready), 0);
    chk("st_count1", 32'(lq_count), 1);
    cyc();
    @(negedge clk); chk("st_resume", 32'(pipe_ready), 1);
    chk("st_count0", 32'(lq_count), 0);
    cyc();
    pipe(5'd15, 32'hA005);
    @(negedge clk); chk("st_p5", 32'(pipe_ready), 1);
    cyc(); idle();
    @(negedge clk); cyc();

    // Full queue forces LOAD_PRI; third load enters right after first dequeue.
    exp_wr(5'd16, 32'hB1); exp_wr(5'd17, 32'hB2); exp_wr(5'd21, 32'hC1);
    exp_wr(5'd18, 32'hB3); exp_wr(5'd22, 32'hC2); exp_wr(5'd19, 32'hB4);
    exp_wr(5'd23, 32'hC3);
    pipe(5'd16, 32'hB1); ld(5'd21, 32'hC1);
    @(negedge clk); chk("fq_ldr0", 32'(ld_ready), 1);
    cyc();
    pipe(5'd17, 32'hB2); ld(5'd22, 32'hC2);
    @(negedge clk); chk("fq_ldr1", 32'(ld_ready), 1);
    cyc();
    pipe(5'd18, 32'hB3); ld(5'd23, 32'hC3);
    @(negedge clk); chk("fq_full_ldr", 32'(ld_ready), 0);
    chk("fq_full_pr", 32'(pipe_ready), 0);
    chk("fq_count2", 32'(lq_count), 2);
    cyc();
    @(negedge clk); chk("fq_ld3_acc", 32'(ld_ready), 1);
    chk("fq_pr_back", 32'(pipe_ready), 1);
    chk("fq_count1", 32'(lq_count), 1);
    cyc();
    pipe(5'd19, 32'hB4); ld_valid = 1'b0;
    @(negedge clk); chk("fq_full2_pr", 32'(pipe_ready), 0);
    chk("fq_count2b", 32'(lq_count), 2);
    cyc();
    @(negedge clk); chk("fq_pr_back2", 32'(pipe_ready), 1);
    cyc(); idle();
    @(negedge clk); chk("fq_count1b", 32'(lq_count), 1);
    cyc();
    @(negedge clk); chk("fq_drained", 32'(lq_count), 0);
    cyc();

    // x0 load and x0 pipe: handshake completes, no write pulse.
    ld(5'd0, 32'hDEAD);
    @(negedge clk); cyc(); idle();
    @(negedge clk); chk("x0_count1", 32'(lq_count), 1);
    cyc();
    @(negedge clk); chk("x0_count0", 32'(lq_count), 0);
    chk("x0_ld_we", 32'(rf_write_params.write_enable), 0);
    cyc();
    pipe(5'd0, 32'hBEEF);
    @(negedge clk); chk("x0_pready", 32'(pipe_ready), 1);
    cyc(); idle();
    @(negedge clk); chk("x0_pipe_we", 32'(rf_write_params.write_enable), 0);
    cyc();

    // No-write pipe request does not block a same-cycle dequeue.
    exp_wr(5'd3, 32'h33);
    ld(5'd3, 32'h33);
    @(negedge clk); cyc(); idle();
    pipe_valid = 1'b1; pipe_params.addr_rd = 5'd4; pipe_data = 32'h44;
    @(negedge clk); chk("nw_pready", 32'(pipe_ready), 1);
    chk("nw_count1", 32'(lq_count), 1);
    cyc(); idle();
    @(negedge clk); chk("nw_count0", 32'(lq_count), 0);
    chk("nw_ld_we", 32'(rf_write_params.write_enable), 1);
    cyc();

    // Reset mid-operation discards two queued loads.
    pipe(5'd0, 32'h0); ld(5'd25, 32'hE1);
    @(negedge clk); cyc();
    ld(5'd26, 32'hE2);
    @(negedge clk); chk("mr_count1", 32'(lq_count), 1);
    cyc(); idle();
    reset_n = 1'b0;
    @(negedge clk); chk("mr_count", 32'(lq_count), 0);
    chk("mr_we", 32'(rf_write_params.write_enable), 0);
    chk("mr_data", rf_write_data, 0);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mr_after_count", 32'(lq_count), 0);
      cyc();
    end

`ifdef WB_ARB_FORWARD_EN
    // Hazard against an enqueuing load, a queued load, and zero sources.
    exp_wr(5'd9, 32'h99);
    pipe(5'd0, 32'h0); ld(5'd9, 32'h99); chk_rs1 = 5'd9;
    @(negedge clk); chk("fw_enq_hit", 32'(lq_hazard), 1);
    cyc();
    ld(5'd0, 32'h0);
    @(negedge clk); chk("fw_q_hit", 32'(lq_hazard), 1);
    cyc();
    ld_valid = 1'b0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    @(negedge clk); chk("fw_zero", 32'(lq_hazard), 0);
    cyc(); idle();
    repeat (3) cyc();
`endif

    repeat (3) cyc();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
